// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter and sequencer sharing one single-port DRAM among NREQ cores.
// Waits out the DRAM preload, issues one access per cycle, and pulses mem_end once every core is done.
module dram_arbiter #(
  parameter int NREQ        = 4,
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int INIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 all_done,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_data,
  output logic                 mem_we,
  output logic                 mem_end,
  input  logic [DW-1:0]        mem_q
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_ENDP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]      state_r;
  logic [1:0]      state_s;
  logic [CW-1:0]   init_cnt_r;
  logic [PW-1:0]   ptr_r;
  logic [NREQ-1:0] done_lat_r;
  logic [NREQ-1:0] rvalid_r;
  logic [AW-1:0]   addr_hold_r;
  logic [DW-1:0]   data_hold_r;
  logic            all_done_r;
  logic            mem_end_r;

  logic [NREQ-1:0] done_seen_s;
  logic [NREQ-1:0] eligible_s;
  logic [NREQ-1:0] gnt_s;
  logic            win_valid_s;
  logic            win_hit_s;
  logic [PW-1:0]   win_idx_s;
  logic [PW-1:0]   ptr_next_s;
  logic [PW:0]     sum_s;
  logic [PW:0]     cand_s;
  logic            grant_any_s;
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_data_s;
  logic            win_we_s;

  // A core's own done masks its request in the very cycle it rises.
  assign done_seen_s = done_lat_r | done;
  assign eligible_s  = req & ~done_seen_s;

  // Round-robin search: first eligible index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_valid_s = 1'b0;
    win_hit_s   = 1'b0;
    win_idx_s   = {PW{1'b0}};
    sum_s       = {(PW+1){1'b0}};
    cand_s      = {(PW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum_s       = {1'b0, ptr_r} + (PW+1)'(k);
      cand_s      = (sum_s >= (PW+1)'(NREQ)) ? (sum_s - (PW+1)'(NREQ)) : sum_s;
      win_hit_s   = !win_valid_s && eligible_s[cand_s[PW-1:0]];
      win_idx_s   = win_hit_s ? cand_s[PW-1:0] : win_idx_s;
      win_valid_s = win_valid_s | win_hit_s;
    end
  end

  assign gnt_s       = ((state_r == ST_ARB) && win_valid_s) ? (NREQ'(1'b1) << win_idx_s) : {NREQ{1'b0}};
  assign grant_any_s = |gnt_s;
  assign win_addr_s  = req_addr[win_idx_s*AW +: AW];
  assign win_data_s  = req_wdata[win_idx_s*DW +: DW];
  assign win_we_s    = req_we[win_idx_s];
  assign ptr_next_s  = (win_idx_s == PW'(NREQ-1)) ? {PW{1'b0}} : (win_idx_s + PW'(1'b1));

  // Next-state decode for the INIT/ARB/ENDP/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: state_s = (init_cnt_r == {CW{1'b0}}) ? ST_ARB : ST_INIT;
      ST_ARB:  state_s = ((&done_seen_s) && (rvalid_r == {NREQ{1'b0}})) ? ST_ENDP : ST_ARB;
      ST_ENDP: state_s = ST_DONE;
      ST_DONE: state_s = ST_DONE;
      default: state_s = ST_INIT;
    endcase
  end

  // Sequencer state, preload countdown and done latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= CW'(INIT_CYCLES);
      done_lat_r <= {NREQ{1'b0}};
      all_done_r <= 1'b0;
      mem_end_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      init_cnt_r <= ((state_r == ST_INIT) && (init_cnt_r != {CW{1'b0}})) ? (init_cnt_r - CW'(1'b1)) : init_cnt_r;
      done_lat_r <= done_seen_s;
      all_done_r <= (state_s == ST_DONE);
      mem_end_r  <= (state_s == ST_ENDP);
    end
  end

  // Grant bookkeeping: pointer advance, read-return tag, and held DRAM address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= {PW{1'b0}};
      rvalid_r    <= {NREQ{1'b0}};
      addr_hold_r <= {AW{1'b0}};
      data_hold_r <= {DW{1'b0}};
    end else begin
      rvalid_r <= gnt_s & ~req_we;
      if (grant_any_s) begin
        ptr_r       <= ptr_next_s;
        addr_hold_r <= win_addr_s;
        data_hold_r <= win_data_s;
      end else begin
        ptr_r       <= ptr_r;
        addr_hold_r <= addr_hold_r;
        data_hold_r <= data_hold_r;
      end
    end
  end

  assign gnt      = gnt_s;
  assign rvalid   = rvalid_r;
  assign rdata    = mem_q;
  assign all_done = all_done_r;
  assign mem_end  = mem_end_r;
  assign mem_we   = grant_any_s & win_we_s;
  assign mem_addr = grant_any_s ? win_addr_s : addr_hold_r;
  assign mem_data = grant_any_s ? win_data_s : data_hold_r;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus a randomized run
// against a transaction-level round-robin model with a simple DRAM model.
module tb_dram_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int INIT_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req, req_we, done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic all_done, mem_we, mem_end;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] dram [0:4095];
  logic [AW-1:0] q_addr = '0;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .all_done(all_done), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_end(mem_end), .mem_q(mem_q)
  );

  // single-port DRAM: registered read address, one-cycle read latency, not reset
  always @(posedge clk) begin
    if (mem_we) dram[mem_addr] <= mem_data;
    q_addr <= mem_addr;
  end
  assign mem_q = dram[q_addr];

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] av;
    av = a;
    return 32'h5A3C_0000 ^ (av * 32'd40503);
  endfunction

  task automatic clear_inputs();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; done = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // after return the next negedge is cycle 0
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    req = 4'b1111;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if ({gnt, rvalid, all_done, mem_we, mem_end, mem_addr, mem_data} !== '0) begin
      n_bad++;
      $display("FAIL reset gnt=%b rvalid=%b all_done=%b we=%b end=%b addr=%h data=%h, all required 0",
               gnt, rvalid, all_done, mem_we, mem_end, mem_addr, mem_data);
    end
  endtask

  task automatic test_first_read();
    clear_inputs();
    set_req(0, 1'b0, 12'h005, 32'h0);
    req = 4'b0001;
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) req = 4'b0000;
      #1;
      n_total++;
      if (c < 2) begin
        if (gnt !== 4'b0000 || mem_we !== 1'b0) begin
          n_bad++;
          $display("FAIL first_read_idle c=%0d gnt=%b we=%b, required 0000/0", c, gnt, mem_we);
        end
      end else if (c == 2) begin
        if (gnt !== 4'b0001 || mem_addr !== 12'h005) begin
          n_bad++;
          $display("FAIL first_read_gnt gnt=%b addr=%h, required 0001/005", gnt, mem_addr);
        end
      end else begin
        if (rvalid !== 4'b0001 || rdata !== pat(5)) begin
          n_bad++;
          $display("FAIL first_read_data rvalid=%b rdata=%h, required 0001/%h", rvalid, rdata, pat(5));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    clear_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 12'h020 + 12'(i), 32'h0);
    req = 4'b1111;
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) req = 4'b0000;
      #1;
      if (c <= 7) begin
        n_total++;
        if (gnt !== ((c < 2) ? 4'b0000 : (4'b0001 << ((c - 2) % 4)))) begin
          n_bad++;
          $display("FAIL rr_gnt c=%0d gnt=%b, required %b", c, gnt, (c < 2) ? 4'b0000 : (4'b0001 << ((c - 2) % 4)));
        end
      end
      if (c >= 3) begin
        n_total++;
        if (rvalid !== (4'b0001 << ((c - 3) % 4)) || rdata !== pat(32 + (c - 3) % 4)) begin
          n_bad++;
          $display("FAIL rr_rdata c=%0d rvalid=%b rdata=%h, required %b/%h", c, rvalid, rdata,
                   4'b0001 << ((c - 3) % 4), pat(32 + (c - 3) % 4));
        end
      end
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    apply_reset();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        set_req(1, 1'b1, 12'h010, 32'h0000_00AA);
        req = 4'b0010;
      end else if (c == 3) begin
        set_req(2, 1'b0, 12'h010, 32'h0);
        req = 4'b0100;
      end else begin
        req = 4'b0000;
      end
      #1;
      n_total++;
      if (c < 2) begin
        if (mem_we !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_idle c=%0d we=%b, required 0", c, mem_we);
        end
      end else if (c == 2) begin
        if (gnt !== 4'b0010 || mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_data !== 32'h0000_00AA) begin
          n_bad++;
          $display("FAIL wr_grant gnt=%b we=%b addr=%h data=%h, required 0010/1/010/000000aa", gnt, mem_we, mem_addr, mem_data);
        end
      end else if (c == 3) begin
        if (gnt !== 4'b0100 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
          n_bad++;
          $display("FAIL rd_grant gnt=%b we=%b addr=%h, required 0100/0/010", gnt, mem_we, mem_addr);
        end
      end else begin
        if (rvalid !== 4'b0100 || rdata !== 32'h0000_00AA || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
          n_bad++;
          $display("FAIL rd_back rvalid=%b rdata=%h we=%b addr=%h, required 0100/000000aa/0/010 (held)",
                   rvalid, rdata, mem_we, mem_addr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    apply_reset();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      req = (c >= 2 && c <= 5) ? 4'b1000 : 4'b0000;
      set_req(3, 1'b0, 12'h100 + 12'(c), 32'h0);
      #1;
      if (c >= 2 && c <= 5) begin
        n_total++;
        if (gnt !== 4'b1000 || mem_addr !== 12'h100 + 12'(c)) begin
          n_bad++;
          $display("FAIL b2b_gnt c=%0d gnt=%b addr=%h, required 1000/%h", c, gnt, mem_addr, 12'h100 + 12'(c));
        end
      end
      if (c >= 3) begin
        n_total++;
        if (rvalid !== 4'b1000 || rdata !== pat(256 + c - 1)) begin
          n_bad++;
          $display("FAIL b2b_rdata c=%0d rvalid=%b rdata=%h, required 1000/%h", c, rvalid, rdata, pat(256 + c - 1));
        end
      end
    end
  endtask

  task automatic test_done_end();
    logic [3:0] exp_v;
    clear_inputs();
    set_req(1, 1'b0, 12'h030, 32'h0);
    apply_reset();
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      req = (c >= 2) ? 4'b0010 : 4'b0000;
      done = {c == 20, c == 15, c == 12, c == 10};
      #1;
      exp_v = {(c >= 2 && c < 12), c == 21, c >= 22, 1'b0};
      n_total++;
      if ({gnt[1], mem_end, all_done, mem_we} !== exp_v || gnt[3:2] !== 2'b00 || gnt[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL done_end c=%0d gnt=%b end=%b all_done=%b we=%b, required gnt[1]=%b end=%b all_done=%b we=0",
                 c, gnt, mem_end, all_done, mem_we, exp_v[3], exp_v[2], exp_v[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 12'h040 + 12'(i), 32'h0);
    req = 4'b0001;
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        req = 4'b1111;
        rst_n = 1'b0;
      end
      #1;
      if (c == 2) begin
        n_total++;
        if (gnt !== 4'b0001) begin
          n_bad++;
          $display("FAIL mid_pre_gnt gnt=%b, required 0001", gnt);
        end
      end
      if (c == 3) begin
        n_total++;
        if (rvalid !== 4'b0000 || gnt !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 12'h000) begin
          n_bad++;
          $display("FAIL mid_abort rvalid=%b gnt=%b we=%b addr=%h, required 0/0/0/000", rvalid, gnt, mem_we, mem_addr);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      #1;
      n_total++;
      if (gnt !== ((c == 2) ? 4'b0001 : 4'b0000) || (c < 2 && rvalid !== 4'b0000)) begin
        n_bad++;
        $display("FAIL mid_restart c=%0d gnt=%b rvalid=%b, required gnt=%b rvalid=0000",
                 c, gnt, rvalid, (c == 2) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend, p_we, seen, seen_now, elig, exp_gnt, exp_rv, rv_next;
    logic [AW-1:0] p_addr [NREQ];
    logic [DW-1:0] p_data [NREQ];
    logic [DW-1:0] emem [16];
    int dcyc [NREQ];
    logic [AW-1:0] hold_a, exp_a;
    logic [DW-1:0] hold_d, exp_d, exp_rd, rd_next;
    logic exp_we;
    int next_m, w, end_cycle;
    pend = '0; p_we = '0; seen = '0; exp_rv = '0;
    hold_a = '0; hold_d = '0; exp_rd = '0; rd_next = '0;
    next_m = 0; end_cycle = -1;
    for (int i = 0; i < 16; i++) emem[i] = pat(512 + i);
    for (int i = 0; i < NREQ; i++) begin
      dcyc[i] = $urandom_range(120, 240);
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    clear_inputs();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          p_we[i] = 1'($urandom_range(0, 1));
          p_addr[i] = 12'h200 | 12'($urandom_range(0, 15));
          p_data[i] = $urandom;
        end
        req[i] = pend[i];
        set_req(i, p_we[i], p_addr[i], p_data[i]);
        done[i] = (c == dcyc[i]);
      end
      #1;
      seen_now = seen | done;
      elig = pend & ~seen_now;
      w = -1;
      if (c >= INIT_CYCLES && end_cycle < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && elig[(next_m + k) % NREQ]) w = (next_m + k) % NREQ;
        end
      end
      exp_gnt = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      exp_we = (w >= 0) ? p_we[w] : 1'b0;
      exp_a = (w >= 0) ? p_addr[w] : hold_a;
      exp_d = (w >= 0) ? p_data[w] : hold_d;

      n_total++;
      if (gnt !== exp_gnt) begin
        n_bad++;
        $display("FAIL rand_gnt c=%0d gnt=%b, required %b", c, gnt, exp_gnt);
      end
      n_total++;
      if ({mem_we, mem_addr, mem_data} !== {exp_we, exp_a, exp_d}) begin
        n_bad++;
        $display("FAIL rand_port c=%0d we=%b addr=%h data=%h, required %b/%h/%h", c, mem_we, mem_addr, mem_data, exp_we, exp_a, exp_d);
      end
      n_total++;
      if (rvalid !== exp_rv) begin
        n_bad++;
        $display("FAIL rand_rvalid c=%0d rvalid=%b, required %b", c, rvalid, exp_rv);
      end
      if (exp_rv != '0) begin
        n_total++;
        if (rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL rand_rdata c=%0d rdata=%h, required %h", c, rdata, exp_rd);
        end
      end
      n_total++;
      if ({mem_end, all_done} !== {c == end_cycle, end_cycle >= 0 && c > end_cycle}) begin
        n_bad++;
        $display("FAIL rand_end c=%0d end=%b all_done=%b, required %b/%b", c, mem_end, all_done,
                 c == end_cycle, end_cycle >= 0 && c > end_cycle);
      end

      rv_next = '0;
      if (w >= 0) begin
        pend[w] = 1'b0;
        next_m = (w + 1) % NREQ;
        hold_a = exp_a;
        hold_d = exp_d;
        if (p_we[w]) emem[p_addr[w][3:0]] = p_data[w];
        else begin
          rv_next = exp_gnt;
          rd_next = emem[p_addr[w][3:0]];
        end
      end
      if (c >= INIT_CYCLES && end_cycle < 0 && (&seen_now) && exp_rv == '0) end_cycle = c + 1;
      seen = seen_now;
      exp_rv = rv_next;
      exp_rd = rd_next;
    end
    n_total++;
    if (end_cycle < 0) begin
      n_bad++;
      $display("FAIL rand_finish end pulse never reached, required by cycle 300");
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) dram[i] = pat(i);
    clear_inputs();
    test_reset();
    test_first_read();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_done_end();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

endmodule
